// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux arbiter.
//   NUM_REQ : number of requesters (4)
//   SEL_W   : width of the mux select / requester index (2)
//   state_t : arbiter state (IDLE, GRANT)
//   next_rr : cyclic first-set-bit search starting at ptr
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Result of a round-robin pick: winning index plus whether anyone requested.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr, ptr+1, ... (mod NUM_REQ); walking k downwards lets the
  // smallest offset overwrite any later candidate.
  function automatic rr_pick_t next_rr(input logic [NUM_REQ-1:0] req,
                                       input logic [SEL_W-1:0]   ptr);
    rr_pick_t         pick;
    logic [SEL_W-1:0] cand;
    pick.found = 1'b0;
    pick.idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4_bus.sv
// Combinational 4:1 data mux.
//   sel         : select (0..3)
//   d0..d3      : DW-bit data inputs
//   y           : selected data
module mux4_bus
  import arb_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [DW-1:0]    d0,
  input  logic [DW-1:0]    d1,
  input  logic [DW-1:0]    d2,
  input  logic [DW-1:0]    d3,
  output logic [DW-1:0]    y
);

  // Select one of four slices.
  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter owning a shared 4:1 data mux. One requester holds the
// grant for a whole burst (terminated by a last beat); the granted stream is
// passed downstream through a valid/ready handshake.
// Optional build macro: ARB_TIMEOUT_EN - forced release after TIMEOUT
// consecutive-or-not grant cycles without a request from the owner.
//   clk, rst   : clock, synchronous active-high reset
//   req, last  : per-requester valid and last-beat flag
//   data_in    : packed requester data, slice i = data_in[i*DW +: DW]
//   gnt, sel   : registered one-hot grant and mux select
//   out_data, out_valid, out_last : muxed stream (combinational)
//   out_ready  : downstream accept
//   busy       : high while a grant is held
//   timeout    : one-cycle forced-release pulse (0 without ARB_TIMEOUT_EN)
module rr_mux4_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   last,
  input  logic [NUM_REQ*DW-1:0] data_in,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [SEL_W-1:0]     sel,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 timeout
);

  // A zero timeout would release a grant before it could ever be used.
  if (TIMEOUT == 0) begin : g_timeout_range
    $error("rr_mux4_arbiter: TIMEOUT must be nonzero");
  end

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_d;
  logic [SEL_W-1:0]     sel_d;
  logic                 busy_d;
  logic                 beat;
  rr_pick_t             pick;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic                 timeout_d;
`else
  assign timeout = 1'b0;
`endif

  // Shared data mux driven by the registered select.
  mux4_bus #(.DW(DW)) u_mux (
    .sel (sel),
    .d0  (data_in[0*DW +: DW]),
    .d1  (data_in[1*DW +: DW]),
    .d2  (data_in[2*DW +: DW]),
    .d3  (data_in[3*DW +: DW]),
    .y   (out_data)
  );

  assign out_valid = (state_q == GRANT) & req[sel];
  assign out_last  = (state_q == GRANT) & last[sel];
  assign beat      = out_valid & out_ready;
  assign pick      = next_rr(req, ptr_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    sel_d   = sel;
    busy_d  = busy;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << pick.idx;
          sel_d   = pick.idx;
          busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (beat && out_last) begin
          state_d = IDLE;
          gnt_d   = '0;
          sel_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel + SEL_W'(1);
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else if (beat) begin
          cnt_d = '0;
        end else if (!req[sel]) begin
          // This idle cycle brings the count to TIMEOUT: release now.
          if (cnt_q == TO_W'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            gnt_d     = '0;
            sel_d     = '0;
            busy_d    = 1'b0;
            ptr_d     = sel + SEL_W'(1);
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      busy    <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      timeout <= timeout_d;
`endif
    end
  end

endmodule
